// File: rtl/wb_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_pkg
//   Shared types for the register-file write-port arbiter and its pending
//   FIFO.
//   - wb_pend_entry_t : one buffered MDU result (destination, data, stale flag)
//   - grant_src_t     : which source owns the write port this cycle
//   - REG_ZERO        : architectural x0, never written and never tracked
//   - dstOneHot()     : one-hot register mask with x0 forced to zero
// ---------------------------------------------------------------------------
package wb_port_arbiter_pkg;

  // Storage width of the data field.  The arbiter's XLEN parameter must not
  // exceed this value; narrower widths are zero-extended into the entry.
  localparam int PKG_XLEN = 64;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]          dst;
    logic [PKG_XLEN-1:0] data;
    logic                stale;
  } wb_pend_entry_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_PIPE = 2'd1,
    GRANT_MDU  = 2'd2
  } grant_src_t;

  // Writes to x0 are discarded by the architecture, so x0 never shows up in
  // the hazard mask.
  function automatic logic [31:0] dstOneHot(input logic [4:0] dst);
    logic [31:0] mask;
    mask = '0;
    if (dst != REG_ZERO) begin
      mask[dst] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_if
//   Bundles every handshake and data signal around the shared register-file
//   write port.
//   - wb_*      : writeback-stage request (valid, regwrite, dst, data) and
//                 the stall returned to it
//   - mdu_*     : MDU result offer (valid, dst, data) and the FIFO's ready
//   - rf_*      : register-file write port (enable, address, data)
//   - pending_mask : per-register flag for the hazard unit
//   The slave modport is the arbiter's view; the master modport is the view
//   of the surrounding pipeline (or a testbench).
// ---------------------------------------------------------------------------
interface wb_port_arbiter_if #(
  parameter int XLEN = 64
);

  logic            wb_valid;
  logic            wb_regwrite;
  logic [4:0]      wb_dst;
  logic [XLEN-1:0] wb_data;
  logic            wb_stall;

  logic            mdu_valid;
  logic [4:0]      mdu_dst;
  logic [XLEN-1:0] mdu_data;
  logic            mdu_ready;

  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  logic [31:0]     pending_mask;

  modport master (
    output wb_valid, wb_regwrite, wb_dst, wb_data,
    output mdu_valid, mdu_dst, mdu_data,
    input  wb_stall, mdu_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    input  pending_mask
  );

  modport slave (
    input  wb_valid, wb_regwrite, wb_dst, wb_data,
    input  mdu_valid, mdu_dst, mdu_data,
    output wb_stall, mdu_ready,
    output rf_wen, rf_waddr, rf_wdata,
    output pending_mask
  );

endinterface

// File: rtl/wb_port_arbiter_pending_fifo.sv
// ---------------------------------------------------------------------------
// wb_pending_fifo
//   Circular buffer of MDU results waiting for the register-file write port.
//   Ports:
//   - clk, reset   : clock, asynchronous active-high reset (empties buffer)
//   - pushEn/pushEntry : enqueue at the tail (caller guarantees not full)
//   - popEn        : dequeue the head (caller guarantees not empty)
//   - markEn/markDst : set stale on every valid entry whose dst matches
//   - count        : number of valid entries
//   - headValid/headEntry : oldest entry
//   - entryLive/entryDst : per-slot valid-and-not-stale flag and destination
// ---------------------------------------------------------------------------
module wb_pending_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pushEn,
  input  wb_pend_entry_t           pushEntry,
  input  logic                     popEn,
  input  logic                     markEn,
  input  logic [4:0]               markDst,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     headValid,
  output wb_pend_entry_t           headEntry,
  output logic [DEPTH-1:0]         entryLive,
  output logic [4:0]               entryDst [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_pend_entry_t   mem [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [PTR_W-1:0] slotOffset [DEPTH];
  logic [DEPTH-1:0] slotValid;

  // A slot holds a live entry when its distance from the head (modulo the
  // power-of-two depth) is below the occupancy count.  Deriving validity this
  // way keeps head/tail/count as the only bookkeeping state.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slotOffset[i] = PTR_W'(PTR_W'(i) - headPtr);
      slotValid[i]  = {1'b0, slotOffset[i]} < count;
      entryLive[i]  = slotValid[i] & ~mem[i].stale;
      entryDst[i]   = mem[i].dst;
    end
  end

  assign headValid = (count != '0);
  assign headEntry = mem[headPtr];

  // Storage and pointers.  The stale mark is applied before the push so a
  // newly written tail slot always takes the caller's stale decision; the
  // tail slot is never valid when pushing, so the two cannot collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (markEn && slotValid[i] && (mem[i].dst == markDst)) begin
          mem[i].stale <= 1'b1;
        end
      end
      if (pushEn) begin
        mem[tailPtr] <= pushEntry;
        tailPtr      <= tailPtr + 1'b1;
      end
      if (popEn) begin
        headPtr <= headPtr + 1'b1;
      end
      case ({pushEn, popEn})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single integer register-file write port between the in-order
//   writeback stage and the out-of-band multiply/divide unit.  MDU results
//   wait in a small pending FIFO and drain when the pipeline leaves the port
//   free; a head refused MAX_WAIT times takes the port and stalls writeback.
//   Pipeline writes to a register with a buffered MDU result squash it.
//   Ports:
//   - clk   : clock
//   - reset : asynchronous active-high reset
//   - bus   : slave view of wb_port_arbiter_if (writeback request/stall, MDU
//             offer/ready, register-file write port, pending_mask)
// ---------------------------------------------------------------------------
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input logic              clk,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(MAX_WAIT);

  logic [CNT_W-1:0] count;
  logic             headValid;
  wb_pend_entry_t   headEntry;
  logic [DEPTH-1:0] entryLive;
  logic [4:0]       entryDst [DEPTH];

  logic             pipeReq;
  logic             headLive;
  logic             mduGrant;
  logic             pipeGrant;
  logic             mduReady;
  logic             pushEn;
  logic             popEn;
  logic             pushStale;
  wb_pend_entry_t   pushEntry;
  grant_src_t       grantSrc;
  logic [AGE_W-1:0] age;

  wb_pending_fifo #(
    .DEPTH(DEPTH)
  ) pendingFifo (
    .clk       (clk),
    .reset     (reset),
    .pushEn    (pushEn),
    .pushEntry (pushEntry),
    .popEn     (popEn),
    .markEn    (pipeGrant),
    .markDst   (bus.wb_dst),
    .count     (count),
    .headValid (headValid),
    .headEntry (headEntry),
    .entryLive (entryLive),
    .entryDst  (entryDst)
  );

  // Grant decision.  A stale head never competes for the port: it is popped
  // silently and the pipeline keeps the port that cycle.  A live head yields
  // to the pipeline until its age saturates, then wins and stalls writeback.
  // Ready depends only on the registered count, so a full FIFO refuses an
  // offer even in a cycle where the head drains.  A push is born stale when
  // it targets x0 or when the pipeline writes the same register this cycle.
  always_comb begin
    pipeReq   = bus.wb_valid & bus.wb_regwrite & (bus.wb_dst != REG_ZERO);
    headLive  = headValid & ~headEntry.stale;
    mduGrant  = headLive & (~pipeReq | (age >= AGE_LIMIT));
    pipeGrant = pipeReq & ~mduGrant;
    popEn     = headValid & (headEntry.stale | mduGrant);

    mduReady  = (count < CNT_FULL);
    pushEn    = bus.mdu_valid & mduReady;
    pushStale = (bus.mdu_dst == REG_ZERO) |
                (pipeGrant & (bus.mdu_dst == bus.wb_dst));

    pushEntry       = '0;
    pushEntry.dst   = bus.mdu_dst;
    pushEntry.data  = PKG_XLEN'(bus.mdu_data);
    pushEntry.stale = pushStale;

    grantSrc = GRANT_NONE;
    if (!reset) begin
      if (mduGrant) begin
        grantSrc = GRANT_MDU;
      end else if (pipeGrant) begin
        grantSrc = GRANT_PIPE;
      end
    end
  end

  // Port outputs follow the granted source combinationally so a pipeline
  // write lands in its own cycle.  Address and data are zero when idle.
  always_comb begin
    bus.rf_wen   = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    case (grantSrc)
      GRANT_PIPE: begin
        bus.rf_wen   = 1'b1;
        bus.rf_waddr = bus.wb_dst;
        bus.rf_wdata = bus.wb_data;
      end
      GRANT_MDU: begin
        bus.rf_wen   = 1'b1;
        bus.rf_waddr = headEntry.dst;
        bus.rf_wdata = headEntry.data[XLEN-1:0];
      end
      default: begin
      end
    endcase
    bus.wb_stall  = ~reset & pipeReq & mduGrant;
    bus.mdu_ready = mduReady;
  end

  // Hazard mask: every buffered result that will still be written.  Built
  // from registered FIFO state only, so it never reflects this cycle's push.
  always_comb begin
    bus.pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryLive[i]) begin
        bus.pending_mask = bus.pending_mask | dstOneHot(entryDst[i]);
      end
    end
  end

  // Age of the current head: counts refused cycles of a live head, saturates
  // at the forcing threshold and restarts for each new head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age <= '0;
    end else if (popEn) begin
      age <= '0;
    end else if (headLive && !mduGrant && (age < AGE_LIMIT)) begin
      age <= age + AGE_W'(1);
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single integer register-file write port between the in-order writeback stage and the long-latency multiply/divide unit (MDU), which completes out of band.
- MDU results enter a small pending FIFO and drain when the port is free.
- Aging forces an MDU drain when the pipeline keeps the port busy; a pipeline stall is raised for that cycle.
- A pending-destination mask goes to the hazard unit, and WAW-superseded MDU results are squashed.

Parameters:
- XLEN, 64, register data width
- DEPTH, 2, pending FIFO entries (power of two, >=2)
- MAX_WAIT, 4, cycles a FIFO head may be refused before it gets forced priority

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- wb_valid  in  1  writeback stage holds a valid instruction
- wb_regwrite  in  1  that instruction writes a GPR (dataW.regwrite)
- wb_dst  in  5  destination register (dataW.dst)
- wb_data  in  XLEN  write data (dataW.regdata)
- wb_stall  out  1  writeback must hold its instruction this cycle
- mdu_valid  in  1  MDU result offered
- mdu_dst  in  5  MDU destination
- mdu_data  in  XLEN  MDU result
- mdu_ready  out  1  FIFO accepts the offer this cycle
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- pending_mask  out  32  bit r set while a valid, non-stale FIFO entry targets xr

Behaviour:
- Reset state (asynchronous): FIFO empty, all stale bits 0, age=0.
  - rf_wen=0, wb_stall=0, pending_mask=0, mdu_ready=1 while reset is high.
- pipe_req = wb_valid & wb_regwrite & (wb_dst!=0).
  - wb_valid without a write is never stalled.
- mdu_ready = (count<DEPTH). It is computed from registered count only: no pop-through.
- Push on mdu_valid & mdu_ready.
  - A push with mdu_dst==0 is accepted and enqueued already stale.
  - When full, the offer is ignored and the MDU holds.
- Stale head handling:
  - A valid stale head is popped silently: no rf write, and it does not use the port.
  - In that cycle the port goes to the pipeline if pipe_req.
- Grant rules for a valid non-stale head:
  - mdu_grant = head valid & !stale & (!pipe_req | age>=MAX_WAIT).
  - pipe_grant = pipe_req & !mdu_grant.
  - wb_stall = pipe_req & mdu_grant.
  - rf_* are driven combinationally from the granted source.
  - rf_wen=0 with no grant; rf_waddr/rf_wdata are don't-care (drive 0).
- Latency:
  - Pipeline write lands in the same cycle.
  - MDU result lands no earlier than the cycle after its push.
- Age counter:
  - Increments, saturating at MAX_WAIT, each cycle the head is valid, non-stale and not granted.
  - Clears when the head pops.
- WAW squash, on any cycle pipe_grant=1:
  - Every valid FIFO entry with dst==wb_dst gets stale=1.
  - An entry pushed in the same cycle with mdu_dst==wb_dst is enqueued stale.
  - Pipeline writes are always younger than outstanding MDU ops, because the issue stage stalls readers of pending_mask and allows WAW writers.
- Simultaneous push and pop in one cycle: count unchanged; pointers wrap modulo DEPTH.
- pending_mask is registered-state-derived: OR of one-hot dst over valid entries with !stale. It is never set for x0.
- Reset asserted mid-drain discards all entries. Recovery is the MDU/pipeline flush's responsibility.

Decomposition:
- Shared pipes package:
  - wb_pend_entry_t {dst[4:0], data[XLEN-1:0], stale}
  - REG_ZERO=5'd0
- Sub-module wb_pending_fifo:
  - DEPTH-entry circular buffer with head/tail/count.
  - Provides push, pop, parallel stale-mark by dst match, and per-entry valid/stale/dst visibility for pending_mask.
- wb_port_arbiter holds only the grant logic and the age counter.

Test Plan:
- Idle pipeline, mdu push dst=5 data=0xAB at cycle t:
  - rf_wen=1, waddr=5, wdata=0xAB at t+1.
  - pending_mask[5]=1 during t+1 only.
  - wb_stall never set.
- pipe_req every cycle (dst=1..), one MDU push dst=7:
  - MDU refused 4 cycles.
  - On the 5th cycle after the push: rf_waddr=7, wb_stall=1.
  - Pipeline write completes the next cycle; age back to 0.
- Push dst=9, then the pipeline writes x9 before the drain:
  - The entry is dropped with no rf write of the MDU data.
  - pending_mask[9] clears the cycle after the pipeline write.
- Three back-to-back MDU offers with the pipeline writing constantly:
  - mdu_ready=0 on the 3rd offer until a pop.
  - All three values are written in push order with no loss or duplication.
- Pipeline wb_dst=0 with regwrite, plus an MDU push dst=0:
  - rf_wen never asserted for x0.
  - wb_stall=0.
  - pending_mask stays 0.
- FIFO holds 2 entries, reset pulsed high for 1 cycle asynchronously:
  - Outputs go to reset values immediately.
  - Neither entry is ever written after reset deasserts.
